// File: rtl/mmu_arbiter.sv
// mmu_arbiter: round-robin two-requester burst arbiter and beat sequencer for mmu_unit.
// Ports: CLK/RSTN; REQ*/GNT*/BEAT*/DONE*/ERR* per requester; RDATA; SELX..RESP slave side.

package mmu_pkg;
  localparam logic [2:0] TRANSFER_IDLE   = 3'd0;
  localparam logic [2:0] TRANSFER_BUSY   = 3'd1;
  localparam logic [2:0] TRANSFER_NONSEQ = 3'd2;
  localparam logic [2:0] TRANSFER_SEQ    = 3'd3;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_t;
endpackage

module mmu_arbiter
  import mmu_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [31:0] REQ_ADDR0,
  input  logic [31:0] REQ_ADDR1,
  input  logic        REQ_WRITE0,
  input  logic        REQ_WRITE1,
  input  logic [2:0]  REQ_SIZE0,
  input  logic [2:0]  REQ_SIZE1,
  input  logic [2:0]  REQ_BURST0,
  input  logic [2:0]  REQ_BURST1,
  input  logic [31:0] REQ_WDATA0,
  input  logic [31:0] REQ_WDATA1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        BEAT0,
  output logic        BEAT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [31:0] RDATA,
  output logic        SELX,
  output logic [31:0] ADDR,
  output logic [31:0] WRITE_DATA,
  output logic        WRITE,
  output logic [2:0]  SIZE,
  output logic [2:0]  BURST,
  output logic [2:0]  TRANS,
  input  logic [31:0] READ_DATA,
  input  logic        READYOUT,
  input  logic        RESP
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  arb_state_t state_q;
  arb_state_t state_d;

  logic        prio_q;
  logic        owner_q;
  logic        first_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic [2:0]  burst_q;
  logic [4:0]  cnt_q;
  logic [7:0]  wcnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        beat_q;
  logic        done_q;
  logic        err_q;

  logic        in_idle;
  logic        in_issue;
  logic        in_wait;
  logic        grant;
  logic        win;
  logic [31:0] win_addr;
  logic        win_write;
  logic [2:0]  win_size;
  logic [2:0]  win_burst;
  logic [31:0] own_wdata;
  logic        good;
  logic        bad;
  logic        tmo;
  logic        last;
  logic        fin;
  logic        abort;
  logic [31:0] step;
  logic [13:0] total;
  logic [31:0] mask;
  logic [31:0] addr_inc;
  logic [31:0] addr_nxt;

  function automatic logic [4:0] beats(
    input logic [1:0] sel
  );
    unique case (sel)
      2'b00:   beats = 5'd1;
      2'b01:   beats = 5'd4;
      2'b10:   beats = 5'd8;
      default: beats = 5'd16;
    endcase
  endfunction

  assign in_idle  = state_q == ARB_IDLE;
  assign in_issue = state_q == ARB_ISSUE;
  assign in_wait  = state_q == ARB_WAIT;

  assign grant = in_idle & (REQ0 | REQ1);
  // Contention goes to prio; otherwise the lone requester.
  assign win   = (REQ0 & REQ1) ? prio_q : REQ1;

  assign win_addr  = win ? REQ_ADDR1  : REQ_ADDR0;
  assign win_write = win ? REQ_WRITE1 : REQ_WRITE0;
  assign win_size  = win ? REQ_SIZE1  : REQ_SIZE0;
  assign win_burst = win ? REQ_BURST1 : REQ_BURST0;
  assign own_wdata = owner_q ? REQ_WDATA1 : REQ_WDATA0;

  // RESP dominates READYOUT.
  assign good  = in_wait & READYOUT & ~RESP;
  assign bad   = in_wait & RESP;
  assign tmo   = in_wait & ~READYOUT & ~RESP
               & (wcnt_q == WAIT_LAST);
  assign last  = cnt_q == 5'd1;
  assign fin   = good & last;
  assign abort = bad | tmo;

  assign step     = 32'd1 << size_q;
  assign total    = {9'd0, beats(burst_q[2:1])} << size_q;
  assign mask     = {18'd0, total - 14'd1};
  assign addr_inc = addr_q + step;
  assign addr_nxt = burst_q[0]
                  ? (addr_q & ~mask) | (addr_inc & mask)
                  : addr_inc;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (grant) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (fin | abort) state_d = ARB_IDLE;
        else if (good)   state_d = ARB_ISSUE;
      end
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    SELX       = 1'b0;
    TRANS      = TRANSFER_IDLE;
    WRITE_DATA = wdata_q;
    unique case (state_q)
      ARB_ISSUE: begin
        SELX       = 1'b1;
        TRANS      = first_q ? TRANSFER_NONSEQ
                             : TRANSFER_SEQ;
        WRITE_DATA = own_wdata;
      end
      ARB_WAIT: begin
        SELX  = 1'b1;
        TRANS = TRANSFER_BUSY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      first_q <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      burst_q <= 3'd0;
      cnt_q   <= 5'd0;
      wcnt_q  <= 8'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      beat_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      beat_q <= good;
      done_q <= fin;
      err_q  <= abort;
      if (grant) begin
        owner_q <= win;
        addr_q  <= win_addr;
        write_q <= win_write;
        size_q  <= win_size;
        burst_q <= win_burst;
        cnt_q   <= beats(win_burst[2:1]);
        first_q <= 1'b1;
      end
      if (in_issue) begin
        wdata_q <= own_wdata;
        wcnt_q  <= 8'd0;
      end
      if (in_wait & ~READYOUT & ~RESP)
        wcnt_q <= wcnt_q + 8'd1;
      if (good) begin
        rdata_q <= READ_DATA;
        cnt_q   <= cnt_q - 5'd1;
        addr_q  <= addr_nxt;
        first_q <= 1'b0;
      end
      if (fin | abort) prio_q <= ~owner_q;
    end
  end

  assign GNT0  = ~in_idle & ~owner_q;
  assign GNT1  = ~in_idle &  owner_q;
  assign BEAT0 = beat_q & ~owner_q;
  assign BEAT1 = beat_q &  owner_q;
  assign DONE0 = done_q & ~owner_q;
  assign DONE1 = done_q &  owner_q;
  assign ERR0  = err_q  & ~owner_q;
  assign ERR1  = err_q  &  owner_q;
  assign RDATA = rdata_q;
  assign ADDR  = addr_q;
  assign WRITE = write_q;
  assign SIZE  = size_q;
  assign BURST = burst_q;

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Two-requester burst arbiter and sequencer in front of the `mmu_unit` memory slave. It grants one requester at a time with round-robin fairness and holds the grant for a whole burst. It drives the slave's `SELX`/`TRANS`/`ADDR` sequence beat by beat, computing incrementing or wrapping addresses. It returns read data, beat strobes and completion or error status to the owning requester.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent waiting for `READYOUT` on one beat before the burst is aborted with error.
- `CLK` in 1: single clock; all state on the rising edge.
- `RSTN` in 1: reset, asynchronous, active-low.
- `REQ0` / `REQ1` in 1: burst request; held high until `DONE`/`ERR` of that requester.
- `REQ_ADDR0` / `REQ_ADDR1` in 32: burst start address.
- `REQ_WRITE0` / `REQ_WRITE1` in 1: 1 = write burst.
- `REQ_SIZE0` / `REQ_SIZE1` in 3: beat size, giving 1<<SIZE bytes.
- `REQ_BURST0` / `REQ_BURST1` in 3: bits [2:1] select 1, 4, 8 or 16 beats (00/01/10/11); bit 0 = wrapping.
- `REQ_WDATA0` / `REQ_WDATA1` in 32: write data for the current beat; the requester advances it after each `BEAT`.
- `GNT0` / `GNT1` out 1: requester owns the slave; high from grant through `DONE`/`ERR`.
- `BEAT0` / `BEAT1` out 1: one-cycle pulse when a beat completes; `RDATA` is valid on read.
- `DONE0` / `DONE1` out 1: one-cycle pulse when the last beat completes without error.
- `ERR0` / `ERR1` out 1: one-cycle pulse on abort (slave `RESP` or timeout).
- `RDATA` out 32: read data, registered from `READ_DATA`.
- `SELX` out 1: slave select.
- `ADDR` out 32: slave address.
- `WRITE_DATA` out 32: slave write data.
- `WRITE` out 1: slave write enable.
- `SIZE` out 3: slave transfer size.
- `BURST` out 3: slave burst type.
- `TRANS` out 3: slave transfer type; encodings come from `mmu_pkg` (`TRANSFER_IDLE`, `TRANSFER_BUSY`, `TRANSFER_NONSEQ`, `TRANSFER_SEQ`).
- `READ_DATA` in 32: slave read data.
- `READYOUT` in 1: slave ready.
- `RESP` in 1: slave error.

## Operation
- **State machine:**
  - IDLE → ISSUE when any `REQ` is high.
  - ISSUE → WAIT always (one cycle).
  - WAIT → ISSUE on a good beat that is not the last.
  - WAIT → IDLE on the last good beat, on error, or on timeout.
- **Arbitration (IDLE only):**
  - Pointer `prio` starts at 0 after reset.
  - If only one `REQ` is high, that requester wins.
  - If both are high, requester `prio` wins.
  - After every burst end (`DONE` or `ERR`), `prio` becomes the other requester.
  - No preemption; a requester dropping `REQ` mid-burst is ignored until the burst ends.
- **Latching at grant:** the winner's `ADDR`, `WRITE`, `SIZE` and `BURST` are latched into internal registers. The beat count is a 5-bit counter loaded with 1, 4, 8 or 16.
- **ISSUE state:**
  - `SELX`=1.
  - `TRANS` = `TRANSFER_NONSEQ` on the first beat, `TRANSFER_SEQ` on later beats.
  - `ADDR` = current beat address.
  - `WRITE_DATA` = owner's `REQ_WDATA`.
- **WAIT state:**
  - `SELX`=1, `TRANS`=`TRANSFER_BUSY`; `ADDR` and `WRITE_DATA` are held.
  - Sampled `READYOUT`=1 and `RESP`=0 gives a good beat: `RDATA` ← `READ_DATA`, the beat pulse fires, the counter decrements and the address advances.
  - Sampled `RESP`=1 gives an error; `READYOUT` is ignored.
- **Address arithmetic (32-bit):**
  - `step` = 1<<SIZE.
  - `total` = step × beats (14-bit).
  - Incrementing burst: next = addr + step.
  - Wrapping burst: next = (addr & ~(total−1)) | ((addr+step) & (total−1)).
- **Timeout:** an 8-bit wait counter clears on entering WAIT and increments each WAIT cycle. Reaching `TIMEOUT` without a good beat or error ends the burst with `ERR`.
- **Outside ISSUE/WAIT:** `SELX`=0, `TRANS`=`TRANSFER_IDLE`.

## Timing
- **Reset values (asynchronous, while `RSTN`=0):**
  - State IDLE, `prio`=0.
  - All `GNT`, `BEAT`, `DONE`, `ERR` = 0.
  - `SELX`=0, `TRANS`=`TRANSFER_IDLE`.
  - `ADDR`, `WRITE_DATA`, `RDATA` = 0; `WRITE`=0, `SIZE`=0, `BURST`=0.
- **Reset mid-burst:** abandons the burst immediately; no `DONE`/`ERR` pulse.
- **Grant latency:** `REQ` sampled high in IDLE at edge k gives `GNT` and NONSEQ driven after edge k.
- **Beat rate:** minimum 2 cycles per beat (ISSUE + one WAIT). An N-beat burst with an always-ready slave takes 2N cycles from `GNT` rise to the `DONE` pulse.
- **Pulse timing:** `BEAT` is registered and coincident with the new `RDATA`. On the last beat, `BEAT` and `DONE` pulse in the same cycle and `GNT` falls in that cycle.
- **Next grant:** earliest one cycle after `DONE`/`ERR` (the IDLE cycle); back-to-back bursts therefore have one idle cycle between them.
- **`READYOUT` and `RESP` both high:** treated as an error; no `BEAT`.
- **Single-beat burst:** `DONE` follows the first good WAIT.
- **Wrap boundary:** the address never leaves [addr & ~(total−1), +total).

## Test plan
- **Single-beat read:** `REQ0`, `ADDR`=0x08, `BURST`=000, `SIZE`=2, slave ready → one NONSEQ at 0x08; `BEAT0` and `DONE0` pulse together; `RDATA`=mem[2].
- **INCR4 write:** `REQ1`, `ADDR`=0x10, `BURST`=010, `SIZE`=2 → NONSEQ 0x10, then SEQ 0x14, 0x18, 0x1C; four `BEAT1` pulses; `DONE1` 8 cycles after `GNT1` rises.
- **WRAP4 read:** `ADDR`=0x38, `BURST`=011, `SIZE`=2 → beat addresses 0x38, 0x3C, 0x30, 0x34.
- **Simultaneous requests after reset:** `REQ0` and `REQ1` both held with 1-beat bursts → grant order 0, 1, 0, 1; exactly one idle cycle between bursts.
- **Error and timeout:**
  - `RESP`=1 on beat 2 of an INCR4 → `ERR` pulses, no `DONE`, `GNT` drops and `prio` toggles.
  - With `TIMEOUT`=4 and `READYOUT` stuck at 0 → `ERR` after 4 WAIT cycles.
- **Reset mid-burst:** drop `RSTN` during beat 3 of an INCR8 → all outputs return to reset values immediately; after release, a pending `REQ1` is granted first (`prio`=0, only `REQ1` high).
